// File: rtl/mfsk_modulator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mfsk_modulator_pkg
// Description : Shared constants and types for the M-ary FSK transmitter:
//               register map indices, SPI frame length, waveform modes and
//               symbol FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package mfsk_modulator_pkg;

   // Register map (4-bit index carried in the low nibble of the address byte)
   localparam int TONE_BASE  = 0;
   localparam int REG_SPS    = 8;
   localparam int REG_CTRL   = 9;

   // Address byte + 16-bit data word
   localparam int FRAME_BITS = 24;

   typedef enum logic [1:0] {
      MODE_SQUARE     = 2'd0,
      MODE_TRIANGLE   = 2'd1,
      MODE_SAWTOOTH   = 2'd2,
      MODE_SQUARE_ALT = 2'd3
   } wave_mode_e;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_TONE = 1'b1
   } fsm_state_e;

endpackage
`default_nettype wire

// File: rtl/mfsk_modulator_spi.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_if
// Description : Write-only SPI (mode 0) register port. Synchronises the raw
//               SPI pins into clk, shifts MSB-first frames and emits a
//               one-cycle write strobe when a frame of exactly FRAME_BITS
//               bits is closed by cs_n rising.
// Ports       : clk, rst (sync, active low)
//               cs_n, sck, mosi  - raw SPI pins, asynchronous to clk
//               addr [3:0]       - register index of the last frame
//               data [15:0]      - data word of the last frame
//               we               - one-cycle commit strobe
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_if
   import mfsk_modulator_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        cs_n,
   input  logic        sck,
   input  logic        mosi,
   output logic [3:0]  addr,
   output logic [15:0] data,
   output logic        we
);

   localparam int CNT_W = 5;

   logic [1:0]            r_cs_sync;
   logic [1:0]            r_sck_sync;
   logic [1:0]            r_mosi_sync;
   logic                  r_cs_prev;
   logic                  r_sck_prev;
   logic [FRAME_BITS-1:0] r_shift;
   logic [CNT_W-1:0]      r_bit_cnt;

   logic w_cs;
   logic w_sck_rise;
   logic w_cs_rise;
   logic w_unused_addr_hi;

   assign w_cs       = r_cs_sync[1];
   assign w_sck_rise = r_sck_sync[1] & ~r_sck_prev;
   assign w_cs_rise  = r_cs_sync[1] & ~r_cs_prev;

   always_ff @(posedge clk) begin
      if (!rst) begin
         // Chip select idles high so no false deselect edge follows reset
         r_cs_sync   <= 2'b11;
         r_sck_sync  <= 2'b00;
         r_mosi_sync <= 2'b00;
         r_cs_prev   <= 1'b1;
         r_sck_prev  <= 1'b0;
         r_shift     <= '0;
         r_bit_cnt   <= '0;
      end else begin
         r_cs_sync   <= {r_cs_sync[0], cs_n};
         r_sck_sync  <= {r_sck_sync[0], sck};
         r_mosi_sync <= {r_mosi_sync[0], mosi};
         r_cs_prev   <= r_cs_sync[1];
         r_sck_prev  <= r_sck_sync[1];
         if (w_cs) begin
            r_bit_cnt <= '0;
         end else if (w_sck_rise) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], r_mosi_sync[1]};
            // Saturate so over-long frames can never wrap back to a legal count
            if (r_bit_cnt != '1) begin
               r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
         end
      end
   end

   // Count is still valid in the cycle the deselect edge is seen; it is
   // cleared on the following edge.
   assign we   = w_cs_rise && (r_bit_cnt == CNT_W'(FRAME_BITS));
   assign addr = r_shift[19:16];
   assign data = r_shift[15:0];

   // Upper nibble of the address byte carries no meaning
   assign w_unused_addr_hi = ^r_shift[23:20];

endmodule
`default_nettype wire

// File: rtl/mfsk_modulator.sv
`default_nettype none
// ============================================================================
// Module      : mfsk_modulator
// Description : M-ary FSK transmitter. SPI-programmed tone increments and
//               symbol length drive a phase-continuous NCO; the phase is
//               shaped into a square, triangle or sawtooth sample stream.
// Ports       : clk, rst (sync, active low)
//               cs_n, sck, mosi     - SPI register port (write only)
//               sym_data/valid/ready- symbol stream (ready/valid)
//               sample_out          - registered waveform sample
//               sample_valid        - sample_out carries tone data
//               underrun            - pulse: symbol ended with no successor
// Revision    : 1.0 - initial release
// ============================================================================
module mfsk_modulator
   import mfsk_modulator_pkg::*;
#(
   parameter int SYM_BITS = 1,
   parameter int PHASE_W  = 16,
   parameter int SAMPLE_W = 6,
   parameter int DIV_W    = 12
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cs_n,
   input  logic                sck,
   input  logic                mosi,
   input  logic [SYM_BITS-1:0] sym_data,
   input  logic                sym_valid,
   output logic                sym_ready,
   output logic [SAMPLE_W-1:0] sample_out,
   output logic                sample_valid,
   output logic                underrun
);

   localparam int NUM_TONES = 1 << SYM_BITS;
   localparam logic [SAMPLE_W-1:0] C_MIDSCALE = {1'b1, {(SAMPLE_W-1){1'b0}}};

   logic [3:0]  w_addr;
   logic [15:0] w_data;
   logic        w_we;

   spi_reg_if u_spi (
      .clk  (clk),
      .rst  (rst),
      .cs_n (cs_n),
      .sck  (sck),
      .mosi (mosi),
      .addr (w_addr),
      .data (w_data),
      .we   (w_we)
   );

   // ---------------- Register bank ----------------
   logic [PHASE_W-1:0] r_tone [NUM_TONES];
   logic [DIV_W-1:0]   r_sps;
   logic               r_enable;
   wave_mode_e         r_mode;

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_TONES; i++) begin
            r_tone[i] <= '0;
         end
         r_sps    <= '0;
         r_enable <= 1'b0;
         r_mode   <= MODE_SQUARE;
      end else if (w_we) begin
         // Indices beyond the tone bank simply match nothing
         for (int i = 0; i < NUM_TONES; i++) begin
            if (w_addr == 4'(TONE_BASE + i)) begin
               r_tone[i] <= w_data[PHASE_W-1:0];
            end
         end
         if (w_addr == 4'(REG_SPS)) begin
            r_sps <= w_data[DIV_W-1:0];
         end
         if (w_addr == 4'(REG_CTRL)) begin
            r_enable <= w_data[0];
            r_mode   <= wave_mode_e'(w_data[2:1]);
         end
      end
   end

   // ---------------- Symbol FSM ----------------
   fsm_state_e         r_state;
   fsm_state_e         w_next_state;
   logic               w_sym_ready;
   logic               w_accept;
   logic               w_tone_active;
   logic [DIV_W-1:0]   w_sym_len_m1;
   logic [PHASE_W-1:0] r_phase;
   logic [PHASE_W-1:0] r_inc;
   logic [DIV_W-1:0]   r_cnt;
   logic               r_end_pend;

   assign w_accept      = sym_valid && w_sym_ready;
   assign w_tone_active = (r_state == ST_TONE) && r_enable;
   // SPS of zero behaves as a one-clock symbol
   assign w_sym_len_m1  = (r_sps == '0) ? '0 : r_sps - DIV_W'(1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next_state = ST_TONE;
            end
         end
         ST_TONE: begin
            if (!r_enable) begin
               w_next_state = ST_IDLE;
            end else if ((r_cnt == '0) && !w_accept) begin
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      w_sym_ready = 1'b0;
      case (r_state)
         ST_IDLE: w_sym_ready = r_enable;
         ST_TONE: w_sym_ready = r_enable && (r_cnt == '0);
         default: w_sym_ready = 1'b0;
      endcase
   end

   assign sym_ready = w_sym_ready;

   // ---------------- Shaper ----------------
   logic                w_msb;
   logic [SAMPLE_W-1:0] w_p;
   logic [SAMPLE_W-1:0] w_shaped;

   assign w_msb = r_phase[PHASE_W-1];
   assign w_p   = r_phase[PHASE_W-2 -: SAMPLE_W];

   always_comb begin
      w_shaped = {SAMPLE_W{~w_msb}};
      case (r_mode)
         MODE_TRIANGLE: w_shaped = w_msb ? ~w_p : w_p;
         MODE_SAWTOOTH: w_shaped = r_phase[PHASE_W-1 -: SAMPLE_W];
         default:       w_shaped = {SAMPLE_W{~w_msb}};
      endcase
   end

   // ---------------- NCO datapath and output registers ----------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_phase      <= '0;
         r_inc        <= '0;
         r_cnt        <= '0;
         r_end_pend   <= 1'b0;
         underrun     <= 1'b0;
         sample_valid <= 1'b0;
         sample_out   <= C_MIDSCALE;
      end else begin
         if (w_accept) begin
            r_inc <= r_tone[sym_data];
            r_cnt <= w_sym_len_m1;
         end else if ((r_state == ST_TONE) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - DIV_W'(1);
         end

         // Phase keeps running across symbol reloads (phase continuity);
         // only an enable drop during a tone returns it to zero.
         if (r_state == ST_TONE) begin
            r_phase <= r_enable ? r_phase + r_inc : '0;
         end

         // Delayed one cycle so the pulse lines up with sample_valid falling
         r_end_pend <= w_tone_active && (r_cnt == '0) && !w_accept;
         underrun   <= r_end_pend;

         sample_valid <= w_tone_active;
         sample_out   <= w_tone_active ? w_shaped : C_MIDSCALE;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mfsk_modulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mfsk_modulator
// Description : Directed self-checking bench for mfsk_modulator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mfsk_modulator;

   logic       clk;
   logic       rst;
   logic       cs_n;
   logic       sck;
   logic       mosi;
   logic [0:0] sym_data;
   logic       sym_valid;
   logic       sym_ready;
   logic [5:0] sample_out;
   logic       sample_valid;
   logic       underrun;

   int          n_err;
   int          n_chk;
   int          n_ur;
   logic [15:0] exp_ph;
   logic [15:0] tone_m [2];
   int          sps_m;
   int          mode_m;

   mfsk_modulator #(
      .SYM_BITS (1),
      .PHASE_W  (16),
      .SAMPLE_W (6),
      .DIV_W    (12)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cs_n         (cs_n),
      .sck          (sck),
      .mosi         (mosi),
      .sym_data     (sym_data),
      .sym_valid    (sym_valid),
      .sym_ready    (sym_ready),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .underrun     (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (underrun === 1'b1) n_ur++;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [5:0] shape(input logic [15:0] ph);
      case (mode_m)
         1:       shape = ph[15] ? ~ph[14:9] : ph[14:9];
         2:       shape = ph[15:10];
         default: shape = {6{~ph[15]}};
      endcase
   endfunction

   task automatic spi_frame(input int nbits, input logic [7:0] a, input logic [15:0] d);
      logic [23:0] w;
      w    = {a, d};
      cs_n = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         mosi = w[23-i];
         repeat (4) @(negedge clk);
         sck = 1'b1;
         repeat (4) @(negedge clk);
         sck = 1'b0;
      end
      repeat (4) @(negedge clk);
      cs_n = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic spi_write(input logic [7:0] a, input logic [15:0] d);
      spi_frame(24, a, d);
   endtask

   // Offers n symbols back to back (valid held), checking every sample,
   // the ready pattern, the final underrun pulse and the return to midscale.
   task automatic run_syms(input int n, input int s0, input int s1, input int s2);
      int   seq [3];
      int   acc;
      int   n_rdy;
      int   last;
      int   idx;
      bit   prev_fire;
      seq       = '{s0, s1, s2};
      acc       = 0;
      n_rdy     = 0;
      prev_fire = 1'b0;
      last      = n * sps_m;
      for (int c = 0; c <= last + 3; c++) begin
         @(negedge clk);
         if (prev_fire) acc++;
         if (c >= 2 && c <= last + 1) begin
            check("sample", 32'(sample_out), 32'(shape(exp_ph)));
            check("valid", 32'(sample_valid), 32'd1);
            exp_ph = exp_ph + tone_m[seq[(c-2)/sps_m]];
         end else if (c == last + 2) begin
            check("underrun_pulse", 32'(underrun), 32'd1);
            check("valid_fall", 32'(sample_valid), 32'd0);
            check("idle_mid", 32'(sample_out), 32'd32);
         end else if (c == last + 3) begin
            check("underrun_single", 32'(underrun), 32'd0);
         end
         if (c >= 1 && c <= last && sym_ready) n_rdy++;
         idx       = (acc < n) ? acc : 0;
         sym_valid = (acc < n);
         sym_data  = 1'(seq[idx]);
         prev_fire = sym_ready && sym_valid;
      end
      sym_valid = 1'b0;
      check("accepted", 32'(acc), 32'(n));
      check("ready_count", 32'(n_rdy), 32'(n));
   endtask

   task automatic configure();
      spi_write(8'h00, 16'h0400);
      spi_write(8'h01, 16'h0800);
      spi_write(8'h08, 16'd64);
      spi_write(8'h09, 16'h0005);
      tone_m[0] = 16'h0400;
      tone_m[1] = 16'h0800;
      sps_m     = 64;
      mode_m    = 2;
   endtask

   int ur0;

   initial begin
      n_err = 0; n_chk = 0; n_ur = 0;
      rst = 1'b0; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
      sym_data = 1'b0; sym_valid = 1'b0;
      exp_ph = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_sample", 32'(sample_out), 32'd32);
      check("rst_valid", 32'(sample_valid), 32'd0);
      check("rst_ready", 32'(sym_ready), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
      rst = 1'b1;

      configure();
      check("enabled_ready", 32'(sym_ready), 32'd1);

      // Single symbols, sawtooth +1/clk then +2/clk
      exp_ph = '0;
      run_syms(1, 0, 0, 0);
      run_syms(1, 1, 0, 0);
      // Back-to-back 0,1,0 with valid held
      run_syms(3, 0, 1, 0);

      // Shorter symbol: phase stops mid-ramp and the next symbol resumes it
      spi_write(8'h08, 16'd40);
      sps_m = 40;
      run_syms(1, 0, 0, 0);
      check("held_phase", 32'(exp_ph), 32'h0000A000);
      run_syms(1, 0, 0, 0);

      // Other waveform modes
      spi_write(8'h08, 16'd64);
      sps_m = 64;
      spi_write(8'h09, 16'h0003);
      mode_m = 1;
      run_syms(1, 1, 0, 0);
      spi_write(8'h09, 16'h0001);
      mode_m = 0;
      run_syms(1, 1, 0, 0);
      spi_write(8'h09, 16'h0007);
      mode_m = 3;
      run_syms(1, 0, 0, 0);
      spi_write(8'h09, 16'h0005);
      mode_m = 2;

      // Discarded and ignored frames leave the configuration intact
      spi_frame(16, 8'h00, 16'hFFFF);
      spi_write(8'h0C, 16'h0003);
      spi_write(8'h02, 16'hFFFF);
      spi_write(8'h0A, 16'h0000);
      check("ready_after_junk", 32'(sym_ready), 32'd1);
      run_syms(1, 0, 0, 0);

      // Enable cleared mid-symbol
      spi_write(8'h08, 16'd4000);
      @(negedge clk);
      sym_valid = 1'b1; sym_data = 1'b0;
      @(negedge clk);
      sym_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("long_tone_valid", 32'(sample_valid), 32'd1);
      ur0 = n_ur;
      spi_write(8'h09, 16'h0004);
      check("dis_valid", 32'(sample_valid), 32'd0);
      check("dis_sample", 32'(sample_out), 32'd32);
      check("dis_ready", 32'(sym_ready), 32'd0);
      check("dis_no_underrun", 32'(n_ur), 32'(ur0));
      spi_write(8'h08, 16'd64);
      spi_write(8'h09, 16'h0005);
      exp_ph = '0;
      run_syms(1, 0, 0, 0);

      // Reset mid-symbol
      spi_write(8'h08, 16'd4000);
      @(negedge clk);
      sym_valid = 1'b1; sym_data = 1'b1;
      @(negedge clk);
      sym_valid = 1'b0;
      repeat (30) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_rst_sample", 32'(sample_out), 32'd32);
      check("mid_rst_valid", 32'(sample_valid), 32'd0);
      check("mid_rst_ready", 32'(sym_ready), 32'd0);
      check("mid_rst_underrun", 32'(underrun), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 32'(sym_ready), 32'd0);
      configure();
      exp_ph = '0;
      run_syms(1, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mfsk_modulator.md
# mfsk_modulator

Parametrised M-ary FSK transmitter, the next generation of the modem's 2-FSK send path: an SPI-writable bank of 2^SYM_BITS tone phase increments and a programmable symbol length drive a phase-continuous NCO. A ready/valid symbol interface feeds the NCO, and the NCO output is shaped into a SAMPLE_W-bit square, triangle or sawtooth sample stream. It sits between the data source and the sample output pins of the modem top level.

## Interface
- SYM_BITS, 1, bits per symbol; tone count = 2^SYM_BITS; legal range 1..3.
- PHASE_W, 16, phase accumulator width; legal range SAMPLE_W+1..16.
- SAMPLE_W, 6, output sample width.
- DIV_W, 12, symbol-length register width, in clocks.
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  synchronous, active-low reset (asserted at 0).
- cs_n  in  1  SPI chip select, active low, asynchronous to clk.
- sck  in  1  SPI clock, mode 0, asynchronous to clk.
- mosi  in  1  SPI data, MSB first.
- sym_data  in  SYM_BITS  tone index of the offered symbol.
- sym_valid  in  1  symbol offered.
- sym_ready  out  1  symbol accepted on a clk edge where valid&&ready.
- sample_out  out  SAMPLE_W  registered waveform sample.
- sample_valid  out  1  sample_out carries tone data.
- underrun  out  1  one-cycle pulse: symbol ended with no successor.

## Operation
- SPI: cs_n/sck/mosi pass through a 2-FF synchroniser; mosi is shifted on each synchronised sck rising edge while cs_n is low. A frame is 24 bits: address byte (bits[3:0] index, bits[7:4] ignored), then 16-bit data word.
- Commit on synchronised cs_n rising edge only if exactly 24 bits were shifted; any other count discards the frame. Registers are write-only.
- Register index 0..7: TONE[i] = data[PHASE_W-1:0]; writes to i ≥ 2^SYM_BITS are ignored. Index 8: SPS = data[DIV_W-1:0]. Index 9: CTRL (bit0 enable, bits[2:1] mode: 0 square, 1 triangle, 2 sawtooth, 3 = square). Index 10..15: ignored.
- FSM IDLE: sym_ready = CTRL.enable. Phase is held and sample_valid=0. On acceptance, latch inc=TONE[sym_data] and cnt=max(SPS,1)-1, then go to TONE.
- FSM TONE: each cycle phase += inc (mod 2^PHASE_W) and cnt decrements. sym_ready=1 only when cnt==0.
  - If a symbol is accepted at cnt==0, reload inc/cnt with no gap and no phase reset (phase-continuous).
  - If cnt==0 and no symbol is accepted, go to IDLE and pulse underrun.
- Clearing enable in TONE forces IDLE next cycle with phase ← 0 and no underrun pulse. Configuration writes never disturb the active symbol; inc and cnt are latched at acceptance.
- Waveform, with p = phase[PHASE_W-2 -: SAMPLE_W]:
  - square = {SAMPLE_W{~phase[PHASE_W-1]}};
  - sawtooth = phase[PHASE_W-1 -: SAMPLE_W];
  - triangle = phase[PHASE_W-1] ? ~p : p.
  - In IDLE, sample_out = midscale 2^(SAMPLE_W-1).

## Timing
- Reset values:
  - sample_out=midscale, sample_valid=0, sym_ready=0, underrun=0;
  - phase=0, all TONE=0, SPS=0, CTRL=0;
  - FSM=IDLE, SPI shift/bit count cleared.
- Acceptance at edge k: the first sample with the new increment appears on sample_out after edge k+1, with sample_valid=1 from edge k+1.
- A symbol spans exactly max(SPS,1) clocks; back-to-back symbols produce no idle cycle.
- underrun asserts the cycle after the final TONE cycle, concurrent with sample_valid falling.
- Register commit is visible 3 clk after the raw cs_n rises (2 sync + 1 edge detect). sck high and low phases must each be ≥ 3 clk.
- Reset overrides everything, including a mid-frame SPI transfer (the frame is discarded).

## Structure
- Package mfsk_modulator_pkg holds register index constants (TONE_BASE=0, REG_SPS=8, REG_CTRL=9), FRAME_BITS=24, the waveform mode enum and the FSM state enum.
- Sub-module spi_reg_if contains the synchroniser, shift register, bit counter and commit strobe (outputs addr, data, we).
- The top module holds the register bank, FSM, phase accumulator and shaper.

## Test plan
- Reset: hold rst=0 for 2 clk → sample_out=32, sample_valid=0, sym_ready=0, underrun=0.
- Write TONE0=0x0400, TONE1=0x0800, SPS=64, CTRL=0x5 (enable, sawtooth); offer symbol 0 → sample_out 0,1,2,… (+1/clk) for 64 samples. Symbol 1 → +2/clk.
- sym_valid held with symbols 0,1,0 → sym_ready high exactly once per 64 clk, no sample gap, sawtooth value continuous across each boundary.
- Drop sym_valid after one symbol → single underrun pulse, sample_out=32; the next symbol resumes from the held phase.
- SPI frame of only 16 bits, then cs_n high → all registers unchanged; a following 24-bit frame to index 12 → no effect.
- Clear enable mid-symbol → IDLE next cycle, sample_valid=0, no underrun. Re-enable and send a symbol → ramp restarts from phase 0. Pulling rst low mid-symbol gives the same result.
